// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: column/state geometry, unpacker FSM states
// and a column-word extractor used by the column select logic.
package aes_pkg;

   localparam int COL_W    = 32;
   localparam int NUM_COLS = 4;
   localparam int STATE_W  = 128;
   localparam int CNT_W    = 2;

   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Column 0 sits in the most significant word of the state.
   function automatic logic [COL_W-1:0] col_word(input logic [STATE_W-1:0] v,
                                                input logic [CNT_W-1:0]   c);
      col_word = v[STATE_W - 1 - COL_W * int'(c) -: COL_W];
   endfunction

endpackage

// File: rtl/xor_col_sel.sv
// Column select for the unpacker: picks one state column, optionally XORs the
// matching round-key word, and splits it into bytes (zeroed when not enabled).
module xor_col_sel
   import aes_pkg::*;
#(
   parameter bit KEY_XOR = 1'b1
) (
   input  logic [STATE_W-1:0] data_reg,
   input  logic [STATE_W-1:0] key_reg,
   input  logic [CNT_W-1:0]   col,
   input  logic               en,
   output logic [7:0]         b1,
   output logic [7:0]         b2,
   output logic [7:0]         b3,
   output logic [7:0]         b4
);

   logic [COL_W-1:0] key_mask;
   logic [COL_W-1:0] word;

   // Masking rather than a generate keeps key_reg connected in the pass-through build.
   assign key_mask = {COL_W{KEY_XOR}};
   assign word     = en ? (col_word(data_reg, col) ^ (col_word(key_reg, col) & key_mask))
                        : '0;

   assign {b1, b2, b3, b4} = word;

endmodule

// File: rtl/xor_col_unpack.sv
// Column-serial unpacker: latches a 128-bit state and round key, then emits
// four key-mixed 32-bit columns, one per output handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no block held; in_ready=1, outputs zero
//   SEND  | presenting column col of the held block; out_valid=1
module xor_col_unpack
   import aes_pkg::*;
#(
   parameter bit KEY_XOR = 1'b1,
   parameter int IDX_W   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] data_in,
   input  logic [STATE_W-1:0] key_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_b1,
   output logic [7:0]         out_b2,
   output logic [7:0]         out_b3,
   output logic [7:0]         out_b4,
   output logic [IDX_W-1:0]   out_col,
   output logic               out_last
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   col, col_nxt;
   logic [STATE_W-1:0] data_reg;
   logic [STATE_W-1:0] key_reg;
   logic               sending;
   logic               accept;

   assign sending   = (state == SEND);
   assign in_ready  = (state == IDLE) | (sending & (col == LAST_COL) & out_ready);
   assign accept    = in_valid & in_ready;

   assign out_valid = sending;
   assign out_col   = sending ? IDX_W'(col) : '0;
   assign out_last  = sending & (col == LAST_COL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         col      <= '0;
         data_reg <= '0;
         key_reg  <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         if (accept) begin
            data_reg <= data_in;
            key_reg  <= key_in;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SEND;
               col_nxt   = '0;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (col != LAST_COL) begin
                  col_nxt = col + CNT_W'(1);
               end else if (accept) begin
                  // Back-to-back block: restart at column 0 with no idle cycle.
                  col_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   xor_col_sel #(
      .KEY_XOR (KEY_XOR)
   ) u_sel (
      .data_reg (data_reg),
      .key_reg  (key_reg),
      .col      (col),
      .en       (sending),
      .b1       (out_b1),
      .b2       (out_b2),
      .b3       (out_b3),
      .b4       (out_b4)
   );

endmodule
